// File: rtl/ahbl_pcm_fifo_pkg.sv
// Shared constants for the AHB-Lite PCM sample FIFO: register offsets,
// CTRL/STATUS bit positions, bad-offset read value and 16-bit saturation.
package ahbl_pcm_fifo_pkg;

  localparam logic [23:0] OFF_CTRL   = 24'h00_0000;
  localparam logic [23:0] OFF_STATUS = 24'h00_0004;
  localparam logic [23:0] OFF_DATA   = 24'h00_0008;
  localparam logic [23:0] OFF_THR    = 24'h00_000C;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CH_SEL = 1;
  localparam int CTRL_BOTH   = 2;
  localparam int CTRL_FLUSH  = 3;
  localparam int CTRL_SHIFT  = 4;
  localparam int CTRL_IRQ_EN = 8;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_THR_HIT = 3;
  localparam int ST_LEVEL   = 8;

  localparam logic [31:0] BAD_DATA = 32'hBADD_BEEF;

  localparam int PCM_MAX = 32767;
  localparam int PCM_MIN = -32768;

  function automatic logic [15:0] sat16(
    input logic signed [31:0] x
  );
    logic [15:0] r;
    if (x > PCM_MAX) begin
      r = 16'(PCM_MAX);
    end else if (x < PCM_MIN) begin
      r = 16'(PCM_MIN);
    end else begin
      r = x[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pcm_fifo_core.sv
// Circular sample store with wrap-around pointers and occupancy count.
// Ports: HCLK/HRESETn, push/pop/flush, wr_data in, rd_data/full/empty/level out.
module pcm_fifo_core #(
  parameter int DEPTH = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [15:0]              wr_data,
  output logic [15:0]              rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop frees the slot a same-cycle push needs when full
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + (AW+1)'(do_push)
                        - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ahbl_pcm_fifo.sv
// AHB-Lite slave buffering converted I2S samples; CTRL/STATUS/DATA/THR regs.
// Ports: AHB-Lite slave (H*), s_data/s_valid/s_ws sample input, irq out.
// Option PCM_FIFO_DC_FILTER_EN adds a DC-removal stage before the FIFO.
module ahbl_pcm_fifo
  import ahbl_pcm_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HSEL,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_ws,
  output logic        irq
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [23:0] addr_q, addr_d;
  logic        trans_q, trans_d;
  logic        write_q, write_d;
  logic        sel_q, sel_d;
  logic [8:0]  ctrl_q, ctrl_d;
  logic [6:0]  thr_q, thr_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_data_q, pend_data_d;

  logic        we, re;
  logic        wr_ctrl, wr_status, wr_thr;
  logic        flush, pop, push, ovf_set;
  logic        accept, thr_hit;
  logic [15:0] push_data, rd_data;
  logic        full, empty;
  logic [LW-1:0] level;
  logic signed [31:0] shifted;
  logic        unused_ok;

  assign unused_ok = ^{HADDR[31:24], HTRANS[0],
                       HSIZE, HWDATA[31:9]};

  assign HREADYOUT = 1'b1;
  assign irq       = irq_q;

  assign we = trans_q & sel_q & write_q;
  assign re = trans_q & sel_q & ~write_q;

  assign wr_ctrl   = we & (addr_q == OFF_CTRL);
  assign wr_status = we & (addr_q == OFF_STATUS);
  assign wr_thr    = we & (addr_q == OFF_THR);
  assign flush     = wr_ctrl & HWDATA[CTRL_FLUSH];
  assign pop       = re & (addr_q == OFF_DATA);

  assign accept = s_valid & ctrl_q[CTRL_EN]
                & (ctrl_q[CTRL_BOTH]
                   | (s_ws == ctrl_q[CTRL_CH_SEL]));
  assign shifted = $signed(s_data)
                   >>> ctrl_q[CTRL_SHIFT +: 4];

  // a full FIFO with a same-cycle pop accepts the push cleanly
  assign ovf_set = push & full & ~pop & ~flush;
  assign thr_hit = (thr_q != '0) && (7'(level) >= thr_q);

`ifdef PCM_FIFO_DC_FILTER_EN
  logic        dc_vld_q, dc_vld_d;
  logic [15:0] dc_data_q, dc_data_d;
  logic [15:0] x_prev_q, x_prev_d;
  logic [15:0] y_prev_q, y_prev_d;
  logic signed [17:0] x_ext, xp_ext, yp_ext, y_full;
  logic [15:0] y_sat;

  assign x_ext  = {{2{pend_data_q[15]}}, pend_data_q};
  assign xp_ext = {{2{x_prev_q[15]}}, x_prev_q};
  assign yp_ext = {{2{y_prev_q[15]}}, y_prev_q};
  assign y_full = x_ext - xp_ext + yp_ext
                - (yp_ext >>> 8);
  assign y_sat  = sat16(32'(y_full));

  always_comb begin
    dc_vld_d  = pend_vld_q;
    dc_data_d = dc_data_q;
    x_prev_d  = x_prev_q;
    y_prev_d  = y_prev_q;
    if (pend_vld_q) begin
      dc_data_d = y_sat;
      x_prev_d  = pend_data_q;
      y_prev_d  = y_sat;
    end
    if (flush) begin
      x_prev_d = '0;
      y_prev_d = '0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dc_vld_q  <= 1'b0;
      dc_data_q <= '0;
      x_prev_q  <= '0;
      y_prev_q  <= '0;
    end else begin
      dc_vld_q  <= dc_vld_d;
      dc_data_q <= dc_data_d;
      x_prev_q  <= x_prev_d;
      y_prev_q  <= y_prev_d;
    end
  end

  assign push      = dc_vld_q;
  assign push_data = dc_data_q;
`else
  assign push      = pend_vld_q;
  assign push_data = pend_data_q;
`endif

  pcm_fifo_core #(
    .DEPTH(DEPTH)
  ) u_core (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (push_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    addr_d  = addr_q;
    trans_d = trans_q;
    write_d = write_q;
    sel_d   = sel_q;
    if (HREADY) begin
      addr_d  = HADDR[23:0];
      trans_d = HTRANS[1];
      write_d = HWRITE;
      sel_d   = HSEL;
    end
    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
      ctrl_d = HWDATA[8:0];
      ctrl_d[CTRL_FLUSH] = 1'b0;
    end
    thr_d = wr_thr ? HWDATA[6:0] : thr_q;
    ovf_d = ovf_q;
    if (wr_status && HWDATA[ST_OVF]) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    pend_vld_d  = accept;
    pend_data_d = accept ? sat16(shifted)
                         : pend_data_q;
    irq_d = ctrl_q[CTRL_IRQ_EN] & (thr_hit | ovf_q);
  end

  always_comb begin
    HRDATA = BAD_DATA;
    unique case (1'b1)
      addr_q == OFF_CTRL:
        HRDATA = {23'd0, ctrl_q};
      addr_q == OFF_STATUS: begin
        HRDATA = '0;
        HRDATA[ST_LEVEL +: 7] = 7'(level);
        HRDATA[ST_THR_HIT]    = thr_hit;
        HRDATA[ST_OVF]        = ovf_q;
        HRDATA[ST_FULL]       = full;
        HRDATA[ST_EMPTY]      = empty;
      end
      addr_q == OFF_DATA:
        HRDATA = empty ? 32'd0
               : {{16{rd_data[15]}}, rd_data};
      addr_q == OFF_THR:
        HRDATA = {25'd0, thr_q};
      default: HRDATA = BAD_DATA;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q      <= '0;
      trans_q     <= 1'b0;
      write_q     <= 1'b0;
      sel_q       <= 1'b0;
      ctrl_q      <= '0;
      thr_q       <= '0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
    end else begin
      addr_q      <= addr_d;
      trans_q     <= trans_d;
      write_q     <= write_d;
      sel_q       <= sel_d;
      ctrl_q      <= ctrl_d;
      thr_q       <= thr_d;
      ovf_q       <= ovf_d;
      irq_q       <= irq_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
    end
  end

endmodule

// File: tb/tb_ahbl_pcm_fifo.sv
// Scoreboard bench for ahbl_pcm_fifo: directed cases plus random traffic
// checked against a queue-based reference model.
module tb_ahbl_pcm_fifo;

  localparam int DEPTH = 16;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ws;
  logic        irq;

  always #5 HCLK = ~HCLK;

  ahbl_pcm_fifo #(.DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HSEL(HSEL), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .s_data(s_data), .s_valid(s_valid), .s_ws(s_ws),
    .irq(irq)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  function automatic void check(string nm,
                                logic [31:0] got,
                                logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h",
                  nm, got, exp);
  endfunction

  // monitor: tracks read data phases on the bus and scores HRDATA
  logic rd_dphase = 1'b0;
  always @(posedge HCLK)
    rd_dphase <= HRESETn & HSEL & HTRANS[1]
               & ~HWRITE & HREADY;

  always @(negedge HCLK) begin
    if (rd_dphase) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_read: got %08h, none queued",
                 HRDATA);
      end else begin
        check(name_q.pop_front(), HRDATA, exp_q.pop_front());
      end
    end
  end

  // reference model
  int       mq[$];
  bit       m_ovf;
  bit [8:0] m_ctrl;
  int       m_thr;

  function automatic void model_reset();
    mq.delete();
    m_ovf = 0;
    m_ctrl = '0;
    m_thr = 0;
  endfunction

  function automatic int convert(logic [31:0] d, int sh);
    longint v = $signed(d);
    longint p = longint'(1) << sh;
    longint q = v / p;
    if (v < 0 && (v % p) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  function automatic bit accepts(bit ws);
    return m_ctrl[0] && (m_ctrl[2] || ws == m_ctrl[1]);
  endfunction

  function automatic void model_push(int v);
    if (mq.size() == DEPTH) m_ovf = 1;
    else mq.push_back(v);
  endfunction

  function automatic bit m_thr_hit();
    return m_thr != 0 && mq.size() >= m_thr;
  endfunction

  function automatic bit m_irq();
    return m_ctrl[8] && (m_thr_hit() || m_ovf);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    s[14:8] = 7'(mq.size());
    s[3] = m_thr_hit();
    s[2] = m_ovf;
    s[1] = (mq.size() == DEPTH);
    s[0] = (mq.size() == 0);
    return s;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    logic [23:0] off = a[23:0];
    if (off == 24'h0) return {23'd0, m_ctrl};
    if (off == 24'h4) return m_status();
    if (off == 24'h8) begin
      if (mq.size() == 0) return 32'd0;
      return 32'(mq.pop_front());
    end
    if (off == 24'hC) return 32'(m_thr);
    return 32'hBADD_BEEF;
  endfunction

  function automatic void model_write(logic [31:0] a,
                                      logic [31:0] d);
    logic [23:0] off = a[23:0];
    if (off == 24'h0) begin
      if (d[3]) mq.delete();
      m_ctrl = d[8:0];
      m_ctrl[3] = 1'b0;
    end else if (off == 24'h4) begin
      if (d[2]) m_ovf = 0;
    end else if (off == 24'hC) begin
      m_thr = int'(d[6:0]);
    end
  endfunction

  // drivers: every task starts and ends 1 time unit after a rising edge
  task automatic bus_idle();
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0;
  endtask

  task automatic addr_phase(logic [31:0] a, logic wr);
    HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HADDR = a;
  endtask

  task automatic bus_write(logic [31:0] a, logic [31:0] d);
    addr_phase(a, 1'b1);
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = d;
    @(posedge HCLK); #1;
    model_write(a, d);
  endtask

  task automatic bus_read(logic [31:0] a, string nm);
    exp_q.push_back(model_read(a));
    name_q.push_back(nm);
    addr_phase(a, 1'b0);
    @(posedge HCLK); #1;
    bus_idle();
    @(posedge HCLK); #1;
  endtask

  task automatic send(logic [31:0] d, bit ws);
    bit acc = accepts(ws);
    int v = convert(d, int'(m_ctrl[7:4]));
    s_data = d; s_ws = ws; s_valid = 1;
    @(posedge HCLK); #1;
    s_valid = 0;
    @(posedge HCLK); #1;
    if (acc) model_push(v);
  endtask

  // sample push lands in the same cycle as the DATA read data phase
  task automatic push_read(logic [31:0] d, bit ws, string nm);
    bit acc = accepts(ws);
    int v = convert(d, int'(m_ctrl[7:4]));
    exp_q.push_back(model_read(32'h8));
    name_q.push_back(nm);
    if (acc) model_push(v);
    s_data = d; s_ws = ws; s_valid = 1;
    addr_phase(32'h8, 1'b0);
    @(posedge HCLK); #1;
    s_valid = 0;
    bus_idle();
    @(posedge HCLK); #1;
  endtask

  task automatic check_irq(string nm);
    @(posedge HCLK); #1;
    check(nm, {31'd0, irq}, {31'd0, m_irq()});
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] r = $urandom();
    if ($urandom_range(0, 1) == 1) r = {{12{r[19]}}, r[19:0]};
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] offs [7];
    offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10,
             32'h100, 32'h0100_0004};
    HRESETn = 0; HADDR = '0; HTRANS = '0; HWRITE = 0;
    HSIZE = 3'b010; HWDATA = '0; HSEL = 0; HREADY = 1;
    s_data = '0; s_valid = 0; s_ws = 0;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge HCLK) HRESETn = 1;
    @(posedge HCLK); #1;
    check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    bus_read(32'h4, "rst_status");
    bus_read(32'h0, "rst_ctrl");
    bus_read(32'h10, "bad_offset");
    bus_read(32'h8, "empty_data");

    // shift by 8, left channel
    bus_write(32'h0, 32'h81);
    send(32'h0012_3400, 0);
    bus_read(32'h8, "shift8_data");
    bus_read(32'h4, "shift8_empty");

    // saturation both directions
    bus_write(32'h0, 32'h01);
    send(32'h7FFF_FFFF, 0);
    send(32'h8000_0000, 0);
    bus_read(32'h8, "sat_pos");
    bus_read(32'h8, "sat_neg");

    // overflow on 17th push, OVF write-1-clear
    bus_write(32'h0, 32'h81);
    for (int i = 0; i < 17; i++)
      send(32'((i + 1) * 256), 0);
    bus_read(32'h4, "full_ovf_status");
    bus_write(32'h4, 32'h4);
    bus_read(32'h4, "ovf_cleared");

    // push and pop together while full
    push_read(32'h00AB_0000, 0, "full_pushpop_data");
    bus_read(32'h4, "full_pushpop_status");
    for (int i = 0; i < DEPTH; i++)
      bus_read(32'h8, "drain_order");

    // push and pop together while empty
    push_read(32'h0055_0000, 0, "empty_pushpop_data");
    bus_read(32'h4, "empty_pushpop_status");
    bus_read(32'h8, "empty_pushpop_drain");

    // threshold interrupt and flush
    bus_write(32'hC, 32'd4);
    bus_write(32'h0, 32'h181);
    check_irq("irq_lvl0");
    for (int i = 0; i < 3; i++) send(32'(i * 512), 0);
    check_irq("irq_lvl3");
    send(32'h0000_7700, 0);
    check_irq("irq_lvl4");
    bus_read(32'h8, "irq_pop");
    check_irq("irq_after_pop");
    bus_write(32'h0, 32'h189);
    bus_read(32'h4, "flush_status");
    bus_read(32'h0, "flush_ctrl_readback");

    // right channel only
    bus_write(32'hC, 32'd0);
    bus_write(32'h0, 32'h83);
    for (int i = 0; i < 6; i++)
      send(32'((i + 1) * 32'h0001_1100), i[0]);
    bus_read(32'h4, "chsel_status");
    for (int i = 0; i < 4; i++)
      bus_read(32'h8, "chsel_data");

    // random traffic
    for (int i = 0; i < 300; i++) begin
      int op = $urandom_range(0, 11);
      if (op < 5) begin
        send(rand_data(), 1'($urandom_range(0, 1)));
      end else if (op < 7) begin
        bus_read(32'h8, "rnd_data");
      end else if (op == 7) begin
        bus_read(32'h4, "rnd_status");
      end else if (op == 8) begin
        push_read(rand_data(), 1'($urandom_range(0, 1)),
                  "rnd_pushpop");
      end else if (op == 9) begin
        logic [31:0] c = '0;
        c[0] = ($urandom_range(0, 7) != 0);
        c[1] = 1'($urandom_range(0, 1));
        c[2] = 1'($urandom_range(0, 1));
        c[3] = ($urandom_range(0, 15) == 0);
        c[7:4] = 4'($urandom_range(0, 15));
        c[8] = 1'($urandom_range(0, 1));
        bus_write(32'h0, c);
      end else if (op == 10) begin
        if ($urandom_range(0, 1) == 1)
          bus_write(32'hC, 32'($urandom_range(0, 20)));
        else
          bus_write(32'h4, 32'h4);
      end else begin
        bus_read(offs[$urandom_range(0, 6)], "rnd_reg");
      end
      check_irq("rnd_irq");
    end

    // reset while a sample is between capture and push
    bus_write(32'h0, 32'h81);
    send(32'h0000_1100, 0);
    s_data = 32'h0000_2200; s_ws = 0; s_valid = 1;
    @(posedge HCLK); #1;
    s_valid = 0;
    HRESETn = 0;
    #20;
    @(negedge HCLK) HRESETn = 1;
    @(posedge HCLK); #1;
    model_reset();
    bus_read(32'h4, "midrst_status");
    bus_read(32'h0, "midrst_ctrl");
    check_irq("midrst_irq");

    repeat (3) @(posedge HCLK);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahbl_pcm_fifo.md
AHBL_PCM_FIFO -- requirements
Module: ahbl_pcm_fifo

Interface
REQ-001 SHALL have parameter: DEPTH, 16, FIFO entries, power of two, range 4..64.
REQ-002 SHALL have port: HCLK  input  1  clock; all logic is rising-edge.
REQ-003 SHALL have port: HRESETn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: HADDR  input  32  AHB-Lite address; decode uses [23:0].
REQ-005 SHALL have port: HTRANS  input  2  AHB-Lite transfer type; bit 1 marks an active transfer.
REQ-006 SHALL have port: HWRITE  input  1  AHB-Lite write strobe.
REQ-007 SHALL have port: HSIZE  input  3  AHB-Lite size; only 32-bit access is supported.
REQ-008 SHALL have port: HWDATA  input  32  AHB-Lite write data.
REQ-009 SHALL have port: HSEL  input  1  AHB-Lite slave select.
REQ-010 SHALL have port: HREADY  input  1  AHB-Lite bus ready.
REQ-011 SHALL have port: HRDATA  output  32  AHB-Lite read data.
REQ-012 SHALL have port: HREADYOUT  output  1  AHB-Lite ready; tied to 1.
REQ-013 SHALL have port: s_data  input  32  raw sample word from the upstream I2S receiver.
REQ-014 SHALL have port: s_valid  input  1  one-cycle HCLK-domain pulse qualifying s_data.
REQ-015 SHALL have port: s_ws  input  1  channel tag of s_data; 0 = left, 1 = right.
REQ-016 SHALL have port: irq  output  1  level interrupt, active-high.

Function
REQ-017 SHALL register HADDR/HTRANS/HWRITE/HSEL when HREADY=1 and act in the data phase; we = HTRANS_d[1]&HSEL_d&HWRITE_d; re likewise with !HWRITE_d.
REQ-018 SHALL map 0x00 CTRL: [0] EN, [1] CH_SEL, [2] BOTH (accept either channel), [3] FLUSH (write-1, self-clearing, reads 0), [7:4] SHIFT, [8] IRQ_EN.
REQ-019 SHALL map 0x04 STATUS (RO except OVF): [0] EMPTY, [1] FULL, [2] OVF (sticky; write 1 clears), [3] THR_HIT, [14:8] LEVEL.
REQ-020 SHALL map 0x08 DATA: read returns head sample sign-extended to 32 bits and pops it; returns 0 with no pop when EMPTY; writes are ignored.
REQ-021 SHALL map 0x0C THR: [6:0] threshold; all other offsets read 0xBADDBEEF and ignore writes.
REQ-022 SHALL accept a sample when s_valid & EN & (BOTH | s_ws==CH_SEL).
REQ-023 SHALL convert each accepted sample as pcm = s_data arithmetically shifted right by SHIFT, saturated to 16 bits signed: above 32767 gives 32767; below -32768 gives -32768.
REQ-024 SHALL write the converted sample into the FIFO on the cycle after s_valid; LEVEL then increments and is visible to a read data phase that starts one cycle later.
REQ-025 SHALL, on a push while FULL with no same-cycle pop, drop the sample and set OVF.
REQ-026 SHALL, on a simultaneous push and pop, perform both, leaving LEVEL unchanged; this includes the FULL case, in which OVF is not set.
REQ-027 SHALL, on a pop while EMPTY, leave the pointers unchanged; a push in the same cycle still completes.
REQ-028 SHALL give FLUSH priority over a same-cycle push and pop: pointers and LEVEL go to 0; OVF is unchanged.
REQ-029 SHALL keep FIFO contents when EN is cleared; only new pushes stop.
REQ-030 SHALL wrap the read and write pointers modulo DEPTH; LEVEL ranges 0..DEPTH.
REQ-031 SHALL set THR_HIT = (THR!=0) & (LEVEL>=THR) and drive irq = IRQ_EN & (THR_HIT | OVF), registered.

Reset
REQ-032 SHALL, on HRESETn low, asynchronously clear CTRL, THR, OVF, the pointers, LEVEL, irq and the registered address-phase signals, giving EMPTY=1 and HRDATA=0 at offset 0x00.
REQ-033 SHALL, on reset mid-transfer, discard the in-flight sample and the pending pop.

Configuration
REQ-034 SHALL, with PCM_FIFO_DC_FILTER_EN defined, insert a DC-removal stage after saturation: y = x - x_prev + y_prev - (y_prev>>>8), 18-bit internal, re-saturated to 16 bits.
REQ-035 SHALL, with PCM_FIFO_DC_FILTER_EN defined, add one cycle to the REQ-024 push latency and clear x_prev/y_prev on reset and on FLUSH.
REQ-036 SHALL, without PCM_FIFO_DC_FILTER_EN, push the saturated sample directly, with no filter registers present.

Structure
REQ-037 SHALL place the register offsets, CTRL/STATUS bit positions, 0xBADDBEEF and the 16-bit saturation limits in package ahbl_pcm_fifo_pkg.
REQ-038 SHALL implement the storage, pointers and LEVEL as sub-module pcm_fifo_core (push, pop, flush, full, empty, level).

Verification
REQ-039 SHALL cover: EN=1, CH_SEL=0, SHIFT=8; push s_data 0x00123400 with ws=0 -> DATA reads 0x00001234, then EMPTY=1.
REQ-040 SHALL cover: SHIFT=0, s_data 0x7FFFFFFF then 0x80000000 -> reads 0x00007FFF then 0xFFFF8000.
REQ-041 SHALL cover: 17 pushes with DEPTH=16 -> FULL=1, OVF=1, LEVEL=16; write STATUS 0x4 -> OVF=0.
REQ-042 SHALL cover: FULL FIFO with push and DATA read in the same cycle -> LEVEL stays 16, OVF stays 0, and the oldest sample is returned.
REQ-043 SHALL cover: THR=4, IRQ_EN=1; 4 pushes -> irq=1; 1 pop -> irq=0; FLUSH -> LEVEL=0.
REQ-044 SHALL cover: BOTH=0, CH_SEL=1; alternating ws=0/1 pushes of 6 samples -> LEVEL=3, and only the ws=1 samples are stored.
